// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
// The divisor helper maps a wanted clkout frequency onto the act_div encoding.
package clk_div_pkg;

  localparam int              CNT_W_DEF       = 32;
  localparam longint unsigned DEFAULT_DIV_DEF = 64'd25000000;

  // clkout runs at clk_hz / (2 * (div + 1)); returns 0 when the target is unreachable.
  function automatic longint unsigned div_for_freq(
    input longint unsigned clk_hz,
    input longint unsigned out_hz
  );
    if (out_hz == 0 || clk_hz < 2 * out_hz) begin
      return 0;
    end
    return clk_hz / (2 * out_hz) - 1;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Control and status bundle of the divider bank.
// The master drives enables, sync and divisor writes; the slave is the bank.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) ();

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic [NUM_CH-1:0] clkout;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;

  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  clkout, tick, pend
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output clkout, tick, pend
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: wrap counter, shadowed divisor, 50 % clkout and tick pulse.
// A pending divisor only moves into act_div on a wrap, a sync or while disabled.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int              CNT_W       = CNT_W_DEF,
  parameter longint unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clkout,
  output logic             tick,
  output logic             pend
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_div_q, act_div_d;
  logic [CNT_W-1:0] pnd_div_q, pnd_div_d;
  logic             pend_q, pend_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             apply;

  always_comb begin
    wrap      = en && (cnt_q == act_div_q);
    apply     = sync || !en || wrap;
    cnt_d     = cnt_q;
    act_div_d = act_div_q;
    pnd_div_d = pnd_div_q;
    pend_d    = pend_q;
    clkout_d  = clkout_q;
    tick_d    = 1'b0;

    if (wr) begin
      pnd_div_d = wr_div;
      pend_d    = 1'b1;
    end
    // A write landing on an apply event bypasses the shadow register.
    if (apply) begin
      act_div_d = wr ? wr_div : pnd_div_q;
      pend_d    = 1'b0;
    end

    if (sync || !en) begin
      cnt_d    = '0;
      clkout_d = 1'b0;
    end else if (wrap) begin
      cnt_d    = '0;
      clkout_d = ~clkout_q;
      tick_d   = 1'b1;
    end else begin
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q     <= '0;
      act_div_q <= RST_DIV;
      pnd_div_q <= RST_DIV;
      pend_q    <= 1'b0;
      clkout_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      pnd_div_q <= pnd_div_d;
      pend_q    <= pend_d;
      clkout_q  <= clkout_d;
      tick_q    <= tick_d;
    end
  end

  assign clkout = clkout_q;
  assign tick   = tick_q;
  assign pend   = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers sharing one clk.
// Decodes the divisor write bus into per-channel strobes.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int              NUM_CH      = 4,
  parameter int              CNT_W       = CNT_W_DEF,
  parameter longint unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input logic           clk,
  input logic           clr_n,
  clk_div_bank_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] clkout_w;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] pend_w;

  // Channel indices at or above NUM_CH match no strobe, so such writes vanish.
  always_comb begin
    ch_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wr[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk    (clk),
      .clr_n  (clr_n),
      .en     (bus.en[g]),
      .sync   (bus.sync),
      .wr     (ch_wr[g]),
      .wr_div (bus.wr_div),
      .clkout (clkout_w[g]),
      .tick   (tick_w[g]),
      .pend   (pend_w[g])
    );
  end

  assign bus.clkout = clkout_w;
  assign bus.tick   = tick_w;
  assign bus.pend   = pend_w;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: per-cycle scoreboard against a behavioural
// model, a table of divisor/period records, and hand-timed corner sequences.
module tb_clk_div_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int DEF    = 3;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  always #5 clk = ~clk;

  clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_div_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] c;
    logic [NUM_CH-1:0] t;
    logic [NUM_CH-1:0] p;
  } exp_t;

  typedef struct {
    int div;
    int exp_first;
    int exp_period;
    int exp_clk_at_first;
  } per_vec_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] m_cnt [NUM_CH];
  logic [CNT_W-1:0] m_act [NUM_CH];
  logic [CNT_W-1:0] m_pnd [NUM_CH];
  logic [NUM_CH-1:0] m_clk, m_tick, m_pend;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int watch = 0;
  int tick_times[$];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int tick_at(input int idx);
    if (idx < tick_times.size()) return tick_times[idx];
    return -1000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = '0;
      m_act[i] = CNT_W'(DEF);
      m_pnd[i] = CNT_W'(DEF);
    end
    m_clk  = '0;
    m_tick = '0;
    m_pend = '0;
    exp_q.delete();
  endtask

  // Predicts the registered outputs after the coming edge from the current inputs.
  task automatic model_step();
    bit hit, stop, at_end;
    for (int i = 0; i < NUM_CH; i++) begin
      hit    = bus.wr_en && (int'(bus.wr_ch) == i);
      stop   = bus.sync || !bus.en[i];
      at_end = !stop && (m_cnt[i] == m_act[i]);
      m_tick[i] = at_end;
      if (stop) begin
        m_cnt[i] = '0;
        m_clk[i] = 1'b0;
      end else if (at_end) begin
        m_cnt[i] = '0;
        m_clk[i] = ~m_clk[i];
      end else begin
        m_cnt[i] = m_cnt[i] + 8'd1;
      end
      if (stop || at_end) begin
        m_act[i]  = hit ? bus.wr_div : m_pnd[i];
        if (hit) m_pnd[i] = bus.wr_div;
        m_pend[i] = 1'b0;
      end else if (hit) begin
        m_pnd[i]  = bus.wr_div;
        m_pend[i] = 1'b1;
      end
    end
    exp_q.push_back('{c: m_clk, t: m_tick, p: m_pend});
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("clkout@%0d", cyc), int'(bus.clkout), int'(e.c));
      check($sformatf("tick@%0d", cyc), int'(bus.tick), int'(e.t));
      check($sformatf("pend@%0d", cyc), int'(bus.pend), int'(e.p));
    end
    if (bus.tick[watch]) tick_times.push_back(cyc);
  endtask

  task automatic applyStimulus();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_clkout"}, int'(bus.clkout), 0);
    check({tag, "_tick"}, int'(bus.tick), 0);
    check({tag, "_pend"}, int'(bus.pend), 0);
  endtask

  per_vec_t vecs[5];
  int s, rel, clk_first, pend_seen;

  initial begin
    vecs[0] = '{div: 0, exp_first: 1, exp_period: 1, exp_clk_at_first: 1};
    vecs[1] = '{div: 1, exp_first: 2, exp_period: 2, exp_clk_at_first: 1};
    vecs[2] = '{div: 2, exp_first: 3, exp_period: 3, exp_clk_at_first: 1};
    vecs[3] = '{div: 5, exp_first: 6, exp_period: 6, exp_clk_at_first: 1};
    vecs[4] = '{div: 3, exp_first: 4, exp_period: 4, exp_clk_at_first: 1};

    bus.en     = '1;
    bus.sync   = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_div = '0;

    // Reset held with en high: everything stays at zero.
    repeat (2) @(posedge clk);
    #1;
    check_reset_zero("reset_hold");
    clr_n = 1'b1;
    model_reset();

    // Default divisor 3: ticks at 4, 8, 12 and clkout high after the third.
    $display("[TB] default divisor after reset");
    cyc = 0;
    watch = 0;
    tick_times.delete();
    repeat (13) applyStimulus();
    check("default_tick_count", tick_times.size(), 3);
    check("default_first_tick", tick_at(0), 4);
    check("default_tick_period", tick_at(1) - tick_at(0), 4);
    check("default_clkout_hi", int'(bus.clkout), 7);

    // Asynchronous reset mid-period clears outputs without waiting for an edge.
    #2 clr_n = 1'b0;
    #1 check_reset_zero("async_reset");
    @(posedge clk);
    #1 check_reset_zero("async_reset_held");
    clr_n = 1'b1;
    model_reset();

    // Shadow write: channel 1 at div 9, rewritten to 4 while cnt == 2.
    $display("[TB] shadow write");
    bus.sync = 1'b1; bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_div = 8'd9;
    applyStimulus();
    s = cyc;
    bus.sync = 1'b0; bus.wr_en = 1'b0;
    watch = 1;
    tick_times.delete();
    repeat (2) applyStimulus();
    bus.wr_en = 1'b1; bus.wr_div = 8'd4;
    applyStimulus();
    bus.wr_en = 1'b0;
    check("shadow_pend_rise", int'(bus.pend[1]), 1);
    for (int k = 0; k < 16; k++) begin
      applyStimulus();
      rel = cyc - s;
      if (rel == 9)  check("shadow_pend_held", int'(bus.pend[1]), 1);
      if (rel == 10) check("shadow_pend_cleared", int'(bus.pend[1]), 0);
    end
    check("shadow_old_period", tick_at(0) - s, 10);
    check("shadow_new_period", tick_at(1) - s, 15);

    // Write on the exact wrap cycle: 7-cycle period starts at once, pend never seen.
    $display("[TB] write coincident with wrap");
    bus.wr_en = 1'b1; bus.wr_div = 8'd6;
    applyStimulus();
    bus.wr_en = 1'b0;
    pend_seen = int'(bus.pend[1]);
    for (int k = 0; k < 14; k++) begin
      applyStimulus();
      pend_seen += int'(bus.pend[1]);
    end
    check("wrapwr_tick_a", tick_at(2) - s, 20);
    check("wrapwr_tick_b", tick_at(3) - s, 27);
    check("wrapwr_tick_c", tick_at(4) - s, 34);
    check("wrapwr_pend_never", pend_seen, 0);

    // Table of divisors on channel 2, each loaded by a write coinciding with sync.
    $display("[TB] divisor table");
    for (int v = 0; v < 5; v++) begin
      bus.sync = 1'b1; bus.wr_en = 1'b1; bus.wr_ch = 2'd2;
      bus.wr_div = CNT_W'(vecs[v].div);
      applyStimulus();
      s = cyc;
      bus.sync = 1'b0; bus.wr_en = 1'b0;
      watch = 2;
      tick_times.delete();
      clk_first = -1;
      for (int k = 0; k < vecs[v].exp_first + 2 * vecs[v].exp_period; k++) begin
        applyStimulus();
        if (cyc - s == vecs[v].exp_first) clk_first = int'(bus.clkout[2]);
      end
      check($sformatf("table%0d_count", v), tick_times.size(), 3);
      check($sformatf("table%0d_first", v), tick_at(0) - s, vecs[v].exp_first);
      check($sformatf("table%0d_period", v), tick_at(1) - tick_at(0), vecs[v].exp_period);
      check($sformatf("table%0d_clk", v), clk_first, vecs[v].exp_clk_at_first);
    end

    // Out-of-range channel write changes nothing.
    $display("[TB] out-of-range write");
    bus.wr_en = 1'b1; bus.wr_ch = 2'd3; bus.wr_div = 8'd1;
    applyStimulus();
    bus.wr_en = 1'b0;
    check("oor_no_pend", int'(bus.pend), 0);
    tick_times.delete();
    repeat (9) applyStimulus();
    check("oor_period_kept", tick_at(1) - tick_at(0), 4);

    // Sync alignment of div 2 and div 5, then disable channel 0 with a write pending.
    $display("[TB] sync and enable");
    bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_div = 8'd2;
    applyStimulus();
    bus.wr_ch = 2'd1; bus.wr_div = 8'd5;
    applyStimulus();
    bus.wr_en = 1'b0;
    repeat (5) applyStimulus();
    bus.sync = 1'b1;
    applyStimulus();
    bus.sync = 1'b0;
    s = cyc;
    watch = 0;
    for (int k = 0; k < 15; k++) begin
      applyStimulus();
      rel = cyc - s;
      if (rel == 3)  check("align_ch0_only", int'(bus.tick[1:0]), 1);
      if (rel == 6)  check("align_both_6", int'(bus.tick[1:0]), 3);
      if (rel == 12) check("align_both_12", int'(bus.tick[1:0]), 3);
    end
    bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_div = 8'd1;
    applyStimulus();
    bus.wr_en = 1'b0;
    check("dis_pend_before", int'(bus.pend[0]), 1);
    check("dis_clk_before", int'(bus.clkout[0]), 1);
    bus.en = 3'b110;
    applyStimulus();
    check("dis_clkout_low", int'(bus.clkout[0]), 0);
    check("dis_pend_applied", int'(bus.pend[0]), 0);
    check("dis_tick_low", int'(bus.tick[0]), 0);
    bus.en = '1;
    tick_times.delete();
    repeat (4) applyStimulus();
    check("reen_first_tick", tick_at(0) - s, 19);
    check("reen_second_tick", tick_at(1) - s, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of `NUM_CH` independent programmable clock dividers.
- Each channel produces a 50 %-duty divided clock `clkout` and a one-cycle `tick` enable.
- Divisors are runtime-programmable and shadowed, so a divisor change always takes effect on a period boundary, never mid-period.
- The bank sits beside the top-level clock input and feeds display scanning, debounce sampling and the game/stopwatch time base from one `clk`.

## Interface
- `NUM_CH`, 4 — number of divider channels (1..16)
- `CNT_W`, 32 — counter and divisor width
- `DEFAULT_DIV`, 25000000 — reset value of every channel's active and pending divisor
- `clk` in 1 — system clock
- `clr_n` in 1 — reset, asynchronous, active-low
- `en` in NUM_CH — per-channel run enable
- `sync` in 1 — synchronous restart of all channels
- `wr_en` in 1 — divisor write strobe
- `wr_ch` in $clog2(NUM_CH) (min 1) — target channel of the write
- `wr_div` in CNT_W — divisor value to write
- `clkout` out NUM_CH — divided clocks (registered)
- `tick` out NUM_CH — one-cycle terminal-count pulses (registered)
- `pend` out NUM_CH — high while a written divisor has not yet been applied

## Operation
- **Per-channel state:** `cnt`, `act_div` (active), `pnd_div` (pending), `pend` flag, `clkout`, `tick`.
- **Counting:** while `en[i]` is high, `cnt` increments each cycle. When `cnt == act_div`:
  - `cnt` returns to 0;
  - `clkout` toggles;
  - `tick` is 1 on the next cycle only.
- **Period:** the `clkout` period is 2·(act_div+1) cycles and the `tick` period is act_div+1 cycles. `act_div` = 0 gives `tick` stuck at 1 and `clkout` toggling every cycle.
- **Write:** `wr_en` with `wr_ch` < NUM_CH loads `pnd_div[wr_ch]` ← `wr_div` and sets `pend`. A write with `wr_ch` ≥ NUM_CH is ignored. A later write before apply overwrites the earlier one (last write wins).
- **Apply:** on wrap (`cnt == act_div`), on `sync`, or while `en[i]` is low, `act_div` ← `pnd_div` and `pend` clears.
  - If a write to the channel coincides with an apply event, `wr_div` is applied directly (bypass) and `pend` ends the cycle low.
- **Disable:** `en[i]` low forces `cnt` = 0, `clkout` = 0 and `tick` = 0 from the next edge. Re-enabling starts a fresh period from `cnt` = 0.
- **Sync:** `sync` high forces `cnt` = 0, `clkout` = 0 and `tick` = 0 on all channels, and applies pending divisors. `sync` has priority over wrap. Channels released together are phase-aligned.
- **Width rules:**
  - the counter never exceeds `act_div`;
  - no overflow is possible, since `act_div` ≤ 2^CNT_W−1;
  - `cnt` compares with equality only.

## Timing
- **Reset values (`clr_n` low, asynchronous):**
  - `cnt` = 0, `clkout` = 0, `tick` = 0, `pend` = 0;
  - `act_div` = `pnd_div` = `DEFAULT_DIV` truncated to CNT_W.
- **First wrap:** after reset release with `en` high, the first `tick` rises at edge act_div+1.
- **Tick-to-clkout relation:** `tick` and the `clkout` edge appear in the same cycle, both registered one cycle after the cycle where `cnt == act_div`.
- **Write latency:**
  - `pend` rises the edge after `wr_en`;
  - the new divisor governs the period starting after the next wrap. The period in progress completes with the old divisor.
- **Throughput and outputs:** one write per cycle is accepted, with no back-pressure. All outputs are registered, with no combinational input-to-output path.

## Structure
- **Package `clk_div_pkg`:** `CNT_W` default, `DEFAULT_DIV`, and a function converting a target frequency plus clock frequency into a divisor value.
- **Sub-module `clk_div_chan`:** one channel (counter, shadow divisor, `pend`, `clkout`, `tick`). The top module generates `NUM_CH` instances and decodes `wr_ch` into per-channel write strobes.

## Test plan
- **Reset/default:** `DEFAULT_DIV`=3, `en`=all 1 after reset → `tick` every 4 cycles, `clkout` period 8 cycles, first `tick` at cycle 4; all outputs 0 during `clr_n` low, including `clr_n` asserted mid-period.
- **Shadow write:** channel 1 at div 9; write `wr_div`=4 when `cnt`=2 → current period completes at 10 cycles, `pend`=1 until that wrap, following periods are 5 cycles.
- **Write coincident with wrap:** `wr_div`=6 on the exact wrap cycle → 7-cycle period starts immediately, `pend` never observed high.
- **Divisor 0 and out-of-range write:**
  - `wr_div`=0 → `tick` constant 1, `clkout` toggles every cycle;
  - write with `wr_ch`=NUM_CH → no channel changes.
- **Enable/sync alignment:** channels at div 2 and div 5 with different phases; pulse `sync` → both restart at `cnt` 0, ticks coincide every 6 cycles. Drop `en[0]` → `clkout[0]`=0 next edge; pending divisor applied while disabled.
